// File: rtl/strum_controller_if.sv
// Fret/strum inputs and note-select outputs shared between the strum
// controller and whatever drives it (board pins or a testbench).
interface strum_controller_if;
   logic [6:0] frets;
   logic       strum;
   logic [7:0] controlSignals;
   logic       gate;
   logic       busy;

   modport master (output frets, strum, input controlSignals, gate, busy);
   modport slave  (input frets, strum, output controlSignals, gate, busy);
endinterface

// File: rtl/strum_controller.sv
// Debounces guitar-style fret/strum buttons and sequences the frequencyGen
// note select plus a gate through play and release phases.
module strum_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned NOTE_CYCLES     = 12500000,
   parameter int unsigned RELEASE_CYCLES  = 250000,
   parameter logic [6:0]  OPEN_NOTE       = 7'b0000100,
   parameter bit          HAMMER_EN       = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   strum_controller_if.slave bus
);

   localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYCLES - 1);
   localparam logic [23:0] REL_LOAD  = 24'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

   logic [7:0]  sync_a, sync_b, s_prev, clean;
   logic [23:0] dcnt;
   logic        strum_q, armed, strum_evt;
   logic [6:0]  sel;

   state_t      state, state_n;
   logic [23:0] tcnt, tcnt_n;
   logic [6:0]  note, note_n, pend_note, pend_note_n;
   logic        gate_q, gate_n, pend, pend_n, busy_q;

   // armed only sets once a released strum has been accepted, so a strum held
   // through reset cannot fire when its first debounced value lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a  <= '0;
         sync_b  <= '0;
         s_prev  <= '0;
         clean   <= '0;
         dcnt    <= '0;
         strum_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_a  <= {bus.strum, bus.frets};
         sync_b  <= sync_a;
         s_prev  <= sync_b;
         strum_q <= clean[7];
         if (sync_b != s_prev) begin
            dcnt <= '0;
         end else if (dcnt == DEB_LAST) begin
            clean <= sync_b;
            if (!sync_b[7]) armed <= 1'b1;
         end else begin
            dcnt <= dcnt + 24'd1;
         end
      end
   end

   assign strum_evt = clean[7] & ~strum_q & armed;

   // scanning high to low lets the lowest (highest-pitch) fret overwrite the rest
   always_comb begin
      sel = OPEN_NOTE;
      for (int i = 6; i >= 0; i--) begin
         if (clean[i]) sel = 7'(1 << i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tcnt      <= '0;
         note      <= '0;
         gate_q    <= 1'b0;
         pend      <= 1'b0;
         pend_note <= '0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         note      <= note_n;
         gate_q    <= gate_n;
         pend      <= pend_n;
         pend_note <= pend_note_n;
         busy_q    <= (state_n != IDLE);
      end
   end

   // A strum landing on the RELEASE expiry is honoured immediately rather
   // than waiting a cycle for pend to register.
   always_comb begin
      state_n     = state;
      tcnt_n      = tcnt;
      note_n      = note;
      gate_n      = gate_q;
      pend_n      = pend;
      pend_note_n = pend_note;
      case (state)
         IDLE: begin
            if (strum_evt) begin
               note_n  = sel;
               gate_n  = 1'b1;
               tcnt_n  = NOTE_LOAD;
               state_n = PLAY;
            end
         end
         PLAY: begin
            if (strum_evt) begin
               note_n = sel;
               tcnt_n = NOTE_LOAD;
            end else begin
               if (HAMMER_EN && (sel != note)) note_n = sel;
               if (tcnt == '0) begin
                  gate_n  = 1'b0;
                  tcnt_n  = REL_LOAD;
                  state_n = RELEASE;
               end else begin
                  tcnt_n = tcnt - 24'd1;
               end
            end
         end
         RELEASE: begin
            if (strum_evt) begin
               pend_n      = 1'b1;
               pend_note_n = sel;
            end
            if (tcnt == '0) begin
               if (pend || strum_evt) begin
                  note_n  = strum_evt ? sel : pend_note;
                  gate_n  = 1'b1;
                  tcnt_n  = NOTE_LOAD;
                  pend_n  = 1'b0;
                  state_n = PLAY;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               tcnt_n = tcnt - 24'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.controlSignals = {1'b0, note};
   assign bus.gate           = gate_q;
   assign bus.busy           = busy_q;

endmodule

// File: doc/strum_controller.md
# strum_controller

Sequences the `frequencyGen` tone generator from raw guitar-style inputs: seven fret buttons and one strum switch. It synchronises and debounces the inputs, then resolves which note is sounding by fret priority. It times each note (play, then release) and drives the generator's one-hot `controlSignals` bus plus a `gate` that the audio output stage ANDs with `soundWave`.

## Interface
- `DEBOUNCE_CYCLES`, 250000: cycles a synchronised input vector must stay stable before it is accepted (10 ms at 25 MHz); range 2..2^24-1.
- `NOTE_CYCLES`, 12500000: gate-high duration per strum (0.5 s); range 1..2^24-1.
- `RELEASE_CYCLES`, 250000: forced gate-low gap after a note; range 1..2^24-1.
- `OPEN_NOTE`, 7'b0000100: note played when strummed with no fret held (E).
- `HAMMER_EN`, 1: when 1, fret changes during PLAY retune without a strum.
- `clk`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frets`  in  7  raw fret buttons, active high; bit6=A, 5=B, 4=C, 3=D, 2=E, 1=F, 0=G.
- `strum`  in  1  raw strum switch, active high.
- `controlSignals`  out  8  one-hot note select to `frequencyGen`; bit7 always 0.
- `gate`  out  1  1 while a note is sounding.
- `busy`  out  1  1 in PLAY or RELEASE.

## Operation
- Input conditioning: `{strum, frets}` pass through a 2-FF synchroniser into vector `s`. A shared 24-bit counter `dcnt` tracks stability. If `s != s_prev`, clear `dcnt`. Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`, load `clean <= s` and hold `dcnt` saturated. Otherwise increment `dcnt`. A glitch shorter than DEBOUNCE_CYCLES never reaches `clean`.
- Strum event: rising edge of `clean[7]`, detected against a registered copy. Strum release is ignored.
- Priority: the lowest set bit of `clean[6:0]` wins (highest pitch, G first). If no bit is set, OPEN_NOTE is selected. The result is always exactly one-hot.
- FSM states: IDLE, PLAY, RELEASE. A 24-bit timer `tcnt` counts down. A `pend` flag and `pend_note` register hold a queued strum.
  - IDLE + strum: `controlSignals <= {0, sel}`, `gate <= 1`, `tcnt <= NOTE_CYCLES-1`, go to PLAY.
  - PLAY + strum: retrigger. Latch new `sel` and reload `tcnt <= NOTE_CYCLES-1`. Stay in PLAY with `gate` held at 1.
  - PLAY, no strum, HAMMER_EN=1, `sel` differs from the current note: update `controlSignals` only. The timer is unchanged.
  - PLAY with `tcnt == 0`: `gate <= 0`, `tcnt <= RELEASE_CYCLES-1`, go to RELEASE.
  - RELEASE + strum: `pend <= 1`, `pend_note <= sel`. A later strum overwrites `pend_note`.
  - RELEASE with `tcnt == 0`: if `pend` is set, start PLAY with `pend_note` and clear `pend`. Otherwise go to IDLE.
  - If a strum and timer expiry occur in the same cycle in PLAY, the strum wins (retrigger). In RELEASE, the strum is queued and honoured on that same expiry.
- `controlSignals` holds the last note after release, so the generator divider never sees an all-zero glitch. Silence is signalled only by `gate`.
- Reset (asynchronous, any state, mid-note included):
  - State becomes IDLE.
  - `controlSignals`, `gate`, `busy`, `pend`, `clean`, synchroniser flops, `dcnt` and `tcnt` all reset to 0.
  - The first post-reset strum requires a fresh 0→1 on `clean[7]`.

## Timing
- Raw input stable for DEBOUNCE_CYCLES+3 cycles guarantees `clean` updates: 2 synchroniser cycles, the compare stage, then the count.
- Clean strum edge at cycle t → `controlSignals`/`gate` registered at t+1.
- `gate` is high for exactly NOTE_CYCLES cycles per un-retriggered strum. It is then low for exactly RELEASE_CYCLES cycles before a queued note starts.
- Hammer-on retune appears 1 cycle after the `clean` fret change.
- `busy` = (state != IDLE), registered with the state.
- All outputs are registers; there are no combinational paths from input to output.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, NOTE_CYCLES=10, RELEASE_CYCLES=3.
- Reset then idle: all outputs 0. Hold frets=7'b0100000 and pulse strum for 8 cycles. Required: `controlSignals=8'h20`, gate high for exactly 10 cycles, then low 3 cycles, then `busy=0`.
- Strum bounce (1-cycle pulses every 2 cycles) with frets=0: no note. A clean hold then plays `8'h04` (OPEN_NOTE).
- Frets=7'b1001001 and strum: `controlSignals=8'h01` (G wins). Release G during PLAY with HAMMER_EN=1: `controlSignals` becomes `8'h08` one cycle after `clean` changes, with gate unbroken.
- Second strum at PLAY cycle 6: the timer reloads, giving gate high for 16 cycles in total.
- Strum during RELEASE with frets=7'b0000010: after the 3-cycle gap, PLAY starts with `8'h02`.
- Assert `rst_n`=0 mid-PLAY: outputs are 0 immediately, with no clock edge needed. After deassert, strum held high does not play until released and re-pressed.
